// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_e      : frame FSM states
//   PAR_EVEN/PAR_ODD: encodings of the PAR_TYP input
//   DATA_WIDTH_MIN/MAX : legal word width bounds
//   parity_bit()    : parity of a word, zero-extended to DATA_WIDTH_MAX
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  // Even parity is the XOR of the word; odd parity is its inverse, so the
  // PAR_TYP encoding can be XORed in directly.
  function automatic logic parity_bit(input logic [DATA_WIDTH_MAX-1:0] word,
                                      input logic                      par_typ);
    return (^word) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
//   clk, rst_n        : clock, synchronous active-low reset
//   push, push_data   : write request and word (ignored while full)
//   pop, pop_data     : read request (ignored while empty), head word
//   full, empty, count: occupancy status; full is registered
module uart_tx_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  full_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;
  logic [CW-1:0]         count_next_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
  assign pop_data  = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, count and registered full flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(FIFO_DEPTH));
    end
  end

  // Storage array; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: words enter a FIFO through a valid/ready
// handshake and are sent LSB-first with optional parity and 1 or 2 stops.
//   CLK_TX, RST_TX            : clock, synchronous active-low reset
//   P_DATA_TX, DATA_VALID_TX  : word and write request
//   DATA_READY_TX             : FIFO not full
//   PAR_EN, PAR_TYP, STOP2    : frame format, latched when a word is popped
//   PRESCALE                  : clocks per bit (0 behaves as 1), latched per frame
//   TX_OUT, Busy, FIFO_COUNT  : serial line, frame in progress, FIFO occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                        CLK_TX,
  input  logic                        RST_TX,
  input  logic [DATA_WIDTH-1:0]       P_DATA_TX,
  input  logic                        DATA_VALID_TX,
  output logic                        DATA_READY_TX,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  input  logic                        STOP2,
  input  logic [PRESCALE_WIDTH-1:0]   PRESCALE,
  output logic                        TX_OUT,
  output logic                        Busy,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);

  localparam int                      BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]           LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = PRESCALE_WIDTH'(1);

  tx_state_e                 state_r, state_next_s;
  logic [PRESCALE_WIDTH-1:0] cnt_r, cnt_next_s;
  logic [PRESCALE_WIDTH-1:0] presc_r, presc_next_s;
  logic [BW-1:0]             bit_r, bit_next_s;
  logic [DATA_WIDTH-1:0]     shift_r, shift_next_s;
  logic                      par_en_r, par_en_next_s;
  logic                      par_bit_r, par_bit_next_s;
  logic                      stop2_r, stop2_next_s;
  logic                      tx_r, tx_next_s;
  logic                      busy_r;
  logic                      bit_done_s;
  logic                      frame_end_s;
  logic                      pop_s;
  logic [DATA_WIDTH-1:0]     fifo_data_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;

  uart_tx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK_TX),
    .rst_n     (RST_TX),
    .push      (DATA_VALID_TX),
    .push_data (P_DATA_TX),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (FIFO_COUNT)
  );

  assign DATA_READY_TX = !fifo_full_s;
  assign TX_OUT        = tx_r;
  assign Busy          = busy_r;

  // Last cycle of the current bit period.
  assign bit_done_s = (cnt_r == presc_r - PRESC_ONE);

  // Next-state, counters, shift register and frame-format latching.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    bit_next_s     = bit_r;
    shift_next_s   = shift_r;
    presc_next_s   = presc_r;
    par_en_next_s  = par_en_r;
    par_bit_next_s = par_bit_r;
    stop2_next_s   = stop2_r;
    frame_end_s    = 1'b0;
    pop_s          = 1'b0;

    if (state_r == ST_IDLE || bit_done_s) begin
      cnt_next_s = {PRESCALE_WIDTH{1'b0}};
    end else begin
      cnt_next_s = cnt_r + PRESC_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        pop_s = !fifo_empty_s;
      end
      ST_START: begin
        if (bit_done_s) state_next_s = ST_DATA;
        else            state_next_s = ST_START;
      end
      ST_DATA: begin
        if (bit_done_s) begin
          shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          if (bit_r == LAST_BIT) begin
            bit_next_s   = {BW{1'b0}};
            state_next_s = par_en_r ? ST_PARITY : ST_STOP1;
          end else begin
            bit_next_s   = bit_r + BW'(1);
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_done_s) state_next_s = ST_STOP1;
        else            state_next_s = ST_PARITY;
      end
      ST_STOP1: begin
        if (bit_done_s && stop2_r) state_next_s = ST_STOP2;
        else                       frame_end_s  = bit_done_s;
      end
      ST_STOP2: begin
        frame_end_s = bit_done_s;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // A frame that ends with data waiting chains straight into the next start bit.
    if (frame_end_s) begin
      pop_s        = !fifo_empty_s;
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_next_s;
    end

    if (pop_s) begin
      state_next_s   = ST_START;
      cnt_next_s     = {PRESCALE_WIDTH{1'b0}};
      bit_next_s     = {BW{1'b0}};
      shift_next_s   = fifo_data_s;
      presc_next_s   = (PRESCALE == {PRESCALE_WIDTH{1'b0}}) ? PRESC_ONE : PRESCALE;
      par_en_next_s  = PAR_EN;
      par_bit_next_s = parity_bit(DATA_WIDTH_MAX'(fifo_data_s), PAR_TYP);
      stop2_next_s   = STOP2;
    end else begin
      presc_next_s   = presc_r;
    end
  end

  // Line level for the state being entered, so TX_OUT is registered yet aligned.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      ST_IDLE:   tx_next_s = 1'b1;
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = shift_next_s[0];
      ST_PARITY: tx_next_s = par_bit_next_s;
      ST_STOP1:  tx_next_s = 1'b1;
      ST_STOP2:  tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase
  end

  // Frame state registers; reset abandons any frame in progress.
  always_ff @(posedge CLK_TX) begin
    if (!RST_TX) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {PRESCALE_WIDTH{1'b0}};
      presc_r   <= PRESC_ONE;
      bit_r     <= {BW{1'b0}};
      shift_r   <= {DATA_WIDTH{1'b0}};
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      presc_r   <= presc_next_s;
      bit_r     <= bit_next_s;
      shift_r   <= shift_next_s;
      par_en_r  <= par_en_next_s;
      par_bit_r <= par_bit_next_s;
      stop2_r   <= stop2_next_s;
      tx_r      <= tx_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, buffered UART transmitter: next generation of the team's single-word UART TX. It accepts words through a valid/ready handshake into an internal FIFO and serialises them LSB-first with optional even/odd parity and one or two stop bits. Bit timing comes from a runtime clocks-per-bit prescaler, so there is no dedicated baud clock. It sits between the system-clock register/DMA side and the TX pin.

## Interface
- DATA_WIDTH, 8, word width; legal 5..9
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2
- PRESCALE_WIDTH, 16, width of PRESCALE
- CLK_TX  in  1  single clock, rising edge
- RST_TX  in  1  reset, synchronous, active-low
- P_DATA_TX  in  DATA_WIDTH  word to send
- DATA_VALID_TX  in  1  write request
- DATA_READY_TX  out  1  FIFO not full; write accepted when VALID&&READY at an edge
- PAR_EN  in  1  1 = parity bit inserted
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  1 = two stop bits
- PRESCALE  in  PRESCALE_WIDTH  CLK_TX cycles per bit; 0 treated as 1
- TX_OUT  out  1  serial line, idle high, registered
- Busy  out  1  frame in progress (state != IDLE)
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  words stored

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: TX_OUT=1. If FIFO_COUNT!=0, pop the head word into the shift register and go to START.
- On that pop, latch PAR_EN, PAR_TYP, STOP2 and PRESCALE (with 0→1) for the entire frame. Mid-frame changes take effect at the next frame.
- START: TX_OUT=0.
- DATA: DATA_WIDTH bits, LSB first.
- PARITY: entered only if latched PAR_EN. The bit is XOR of the word for even, inverted for odd.
- STOP1: TX_OUT=1. Goes to STOP2 if latched STOP2.
- End of the last stop bit: if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Each non-IDLE state lasts exactly PRESCALE cycles, counted by a prescale counter of PRESCALE_WIDTH bits. The bit counter is $clog2(DATA_WIDTH) bits.
- FIFO rules:
  - DATA_READY_TX = (FIFO_COUNT != FIFO_DEPTH), a registered count compare.
  - A write while full is ignored; no overwrite, no error flag.
  - Push and pop in the same cycle: count unchanged.
  - A pop never occurs when empty.
- Reset: all state is cleared at the next edge with RST_TX=0, including mid-frame and mid-write. A frame in progress is abandoned.

## Timing
- Reset values: TX_OUT=1, Busy=0, DATA_READY_TX=1, FIFO_COUNT=0. FSM=IDLE, FIFO pointers=0.
- Write at edge k into an empty FIFO while IDLE:
  - edge k: FIFO_COUNT=1.
  - edge k+1: pop; TX_OUT=0, Busy=1, FIFO_COUNT=0.
- Frame length L = PRESCALE·(1+DATA_WIDTH+PAR_EN+1+STOP2) cycles. Busy stays high for exactly L cycles per isolated frame.
- Back-to-back frames: Busy stays continuously high and TX_OUT goes from the last stop bit straight to the next start bit.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - the legal DATA_WIDTH bounds.
- Sub-module uart_tx_fifo: synchronous FIFO with DATA_WIDTH and FIFO_DEPTH parameters, push/pop ports, full/empty/count outputs.
- Top module contains the FSM, prescale counter, bit counter, shift register and parity logic.

## Test plan
- 0xA5, PAR_EN=1 even, STOP2=0, PRESCALE=4 -> TX_OUT runs 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; Busy high 44 cycles; then TX_OUT=1, Busy=0.
- 0xF4, PAR_EN=0, STOP2=1, PRESCALE=1 -> 0,0,0,1,0,1,1,1,1,1,1 over 11 cycles; Busy high 11 cycles.
- 0xF2, PAR_EN=1 odd, PRESCALE=2 -> data bits 0,1,0,0,1,1,1,1; parity bit 0; stop 1; frame length 22 cycles.
- DATA_VALID_TX held high 6 cycles, FIFO_DEPTH=4, PRESCALE=1, words 0x01..0x06 -> 0x01..0x05 accepted; DATA_READY_TX=0 at the 6th attempt and 0x06 dropped. Five frames sent back-to-back with no idle cycle; Busy continuously high.
- RST_TX=0 for one edge during data bit 3 of a frame with 2 words queued -> next edge TX_OUT=1, Busy=0, FIFO_COUNT=0, DATA_READY_TX=1. A following write of 0x3C transmits a correct frame.
- PRESCALE changed 4→8 mid-frame, second word queued -> the current frame completes at 4 cycles/bit and the next frame runs at 8 cycles/bit.
